// File: rtl/regfile_mp_if.sv
// Register-file bus interface: read ports from decode, write ports from
// writeback, plus the clear-sequencer status seen by the pipeline.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int IDXW = 5,
    parameter int NRD  = 2
) ();

    // Read side: port k uses ra[k*IDXW +: IDXW] and rd[k*XLEN +: XLEN].
    logic [NRD*IDXW-1:0] ra;
    logic [NRD*XLEN-1:0] rd;

    // Write side: two ports packed the same way as the read side.
    logic [1:0]          we;
    logic [2*IDXW-1:0]   wa;
    logic [2*XLEN-1:0]   wd;

    // Clear sequencer status.
    logic                busy;
    logic                clr_done;

    // Pipeline side: drives addresses and write data, receives read data.
    modport master (
        output ra, we, wa, wd,
        input  rd, busy, clr_done
    );

    // Register-file side.
    modport slave (
        input  ra, we, wa, wd,
        output rd, busy, clr_done
    );

endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, same-cycle write-to-read
// bypass, port-1-wins conflict resolution, an optional hardwired-zero entry
// and a clear sequencer that zeroes storage after every reset.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int IDXW     = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus_if
);

    // Elaboration-time sanity checks on the geometry.
    if (DEPTH != (1 << IDXW)) begin : g_bad_idxw
        $error("regfile_mp: DEPTH must equal 2**IDXW");
    end
    if (DEPTH < 4) begin : g_bad_depth
        $error("regfile_mp: DEPTH must be at least 4");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_mp: NRD must be in 1..4");
    end

    localparam bit              ZR       = (ZERO_REG != 0);
    // Entry 0 never needs clearing when it is hardwired, so the sweep skips it.
    localparam logic [IDXW-1:0] PTR_INIT = ZR ? IDXW'(1) : '0;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_DONE,
        ST_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q,   ptr_d;

    logic [XLEN-1:0] rf_q [DEPTH];

    // Unpacked views of the write ports.
    logic [IDXW-1:0] wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;

    assign wa0 = bus_if.wa[0 +: IDXW];
    assign wa1 = bus_if.wa[IDXW +: IDXW];
    assign wd0 = bus_if.wd[0 +: XLEN];
    assign wd1 = bus_if.wd[XLEN +: XLEN];

    // Storage is open for writes and bypass only in DONE/RUN outside reset.
    logic active;
    logic clr_en;
    logic wr0_en, wr1_en;

    assign active = !reset && (state_q == ST_DONE || state_q == ST_RUN);
    assign clr_en = !reset && (state_q == ST_CLEAR);

    // Port 0 yields to port 1 on an address collision; writes to a hardwired
    // zero entry are dropped so that entry is never touched.
    assign wr0_en = active && bus_if.we[0]
                    && !(ZR && wa0 == '0)
                    && !(bus_if.we[1] && wa1 == wa0);
    assign wr1_en = active && bus_if.we[1]
                    && !(ZR && wa1 == '0);

    // Status outputs are forced during reset so the pipeline stalls at once.
    assign bus_if.busy     = reset || (state_q == ST_CLEAR);
    assign bus_if.clr_done = !reset && (state_q == ST_DONE);

    // Sequencer state register; reset restarts the sweep from any state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= PTR_INIT;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sweep sequencing: walk ptr to the last entry, pulse DONE, then run.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + IDXW'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Storage update: the sweep owns the array while clearing, otherwise the
    // two write ports do.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch on purpose; a flop-level reset
        // would blow up into DEPTH*XLEN reset nets and block RAM mapping.
        // Zeroing is done one entry per cycle by the clear sequencer instead.
        if (clr_en) begin
            rf_q[ptr_q] <= '0;
        end else begin
            if (wr0_en) begin
                rf_q[wa0] <= wd0;
            end
            if (wr1_en) begin
                rf_q[wa1] <= wd1;
            end
        end
    end

    // Read ports: hardwired zero, then bypass (port 1 first), then storage.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [IDXW-1:0] ra_k;
        logic [XLEN-1:0] rd_k;

        assign ra_k = bus_if.ra[k*IDXW +: IDXW];

        // Combinational read mux for port k; zero outside DONE/RUN.
        always_comb begin
            rd_k = '0;
            if (active) begin
                if (ZR && ra_k == '0) begin
                    rd_k = '0;
                end else if (bus_if.we[1] && wa1 == ra_k) begin
                    rd_k = wd1;
                end else if (bus_if.we[0] && wa0 == ra_k) begin
                    rd_k = wd0;
                end else begin
                    rd_k = rf_q[ra_k];
                end
            end
        end

        assign bus_if.rd[k*XLEN +: XLEN] = rd_k;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: two instances (hardwired zero on and
// off) driven with identical stimulus and compared against a storage model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int IDXW  = 5;
    localparam int NRD   = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Shared stimulus, fanned out to both instances.
    logic [1:0]      we;
    logic [IDXW-1:0] wa [2];
    logic [XLEN-1:0] wd [2];
    logic [IDXW-1:0] ra [NRD];

    regfile_mp_if #(.XLEN(XLEN), .IDXW(IDXW), .NRD(NRD)) if_z1 ();
    regfile_mp_if #(.XLEN(XLEN), .IDXW(IDXW), .NRD(NRD)) if_z0 ();

    assign if_z1.we = we;
    assign if_z1.wa = {wa[1], wa[0]};
    assign if_z1.wd = {wd[1], wd[0]};
    assign if_z1.ra = {ra[1], ra[0]};
    assign if_z0.we = we;
    assign if_z0.wa = {wa[1], wa[0]};
    assign if_z0.wd = {wd[1], wd[0]};
    assign if_z0.ra = {ra[1], ra[0]};

    regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .IDXW(IDXW), .NRD(NRD), .ZERO_REG(1))
        dut_z1 (.clk(clk), .reset(reset), .bus_if(if_z1.slave));
    regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .IDXW(IDXW), .NRD(NRD), .ZERO_REG(0))
        dut_z0 (.clk(clk), .reset(reset), .bus_if(if_z0.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 is the ZERO_REG=1 instance, index 1 ZERO_REG=0.
    logic [XLEN-1:0] mem [2][DEPTH];
    int              clear_left [2];
    bit              done_now [2];

    function automatic bit zr(int d);
        return d == 0;
    endfunction

    function automatic int sweep_len(int d);
        return zr(d) ? DEPTH - 1 : DEPTH;
    endfunction

    // Model update for one rising edge, using the inputs held across it.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                clear_left[d] = sweep_len(d);
                done_now[d]   = 1'b0;
            end else if (clear_left[d] > 0) begin
                clear_left[d]--;
                if (clear_left[d] == 0) begin
                    done_now[d] = 1'b1;
                    for (int i = 0; i < DEPTH; i++) mem[d][i] = '0;
                end
            end else begin
                // Port 1 applied last, so it wins an address collision.
                if (we[0] && !(zr(d) && wa[0] == 0)) mem[d][wa[0]] = wd[0];
                if (we[1] && !(zr(d) && wa[1] == 0)) mem[d][wa[1]] = wd[1];
                done_now[d] = 1'b0;
            end
        end
    endtask

    function automatic logic exp_busy(int d);
        return reset || clear_left[d] > 0;
    endfunction

    function automatic logic exp_done(int d);
        return !reset && done_now[d];
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(int d, int k);
        if (reset || clear_left[d] > 0) return '0;
        if (zr(d) && ra[k] == 0) return '0;
        if (we[1] && wa[1] == ra[k]) return wd[1];
        if (we[0] && wa[0] == ra[k]) return wd[0];
        return mem[d][ra[k]];
    endfunction

    function automatic logic act_busy(int d);
        return (d == 0) ? if_z1.busy : if_z0.busy;
    endfunction

    function automatic logic act_done(int d);
        return (d == 0) ? if_z1.clr_done : if_z0.clr_done;
    endfunction

    function automatic logic [XLEN-1:0] act_rd(int d, int k);
        return (d == 0) ? if_z1.rd[k*XLEN +: XLEN] : if_z0.rd[k*XLEN +: XLEN];
    endfunction

    task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s busy z%0d", tag, 1 - d), XLEN'(act_busy(d)), XLEN'(exp_busy(d)));
            check($sformatf("%s clr_done z%0d", tag, 1 - d), XLEN'(act_done(d)), XLEN'(exp_done(d)));
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("%s rd%0d z%0d ra=%0d", tag, k, 1 - d, ra[k]), act_rd(d, k), exp_rd(d, k));
            end
        end
    endtask

    // Advance one clock: model sees the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        we    = 2'b00;
        wa[0] = '0;
        wa[1] = '0;
        wd[0] = '0;
        wd[1] = '0;
    endtask

    // Run a sweep just released from reset; measure busy length and pulse.
    task automatic sweep_measure(string tag);
        int busy_cnt [2];
        int done_cnt [2];
        int done_idx [2];
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0;
            done_cnt[d] = 0;
            done_idx[d] = -1;
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            check_all(tag);
            for (int d = 0; d < 2; d++) begin
                if (act_busy(d) === 1'b1) busy_cnt[d]++;
                if (act_done(d) === 1'b1) begin
                    done_cnt[d]++;
                    if (done_idx[d] < 0) done_idx[d] = i;
                end
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s busy cycles z%0d", tag, 1 - d), XLEN'(busy_cnt[d]), XLEN'(sweep_len(d)));
            check($sformatf("%s clr_done pulses z%0d", tag, 1 - d), XLEN'(done_cnt[d]), XLEN'(1));
            check($sformatf("%s clr_done cycle z%0d", tag, 1 - d), XLEN'(done_idx[d]), XLEN'(sweep_len(d)));
        end
    endtask

    task automatic read_all_zero(string tag);
        for (int a = 0; a < DEPTH; a++) begin
            ra[0] = IDXW'(a);
            ra[1] = IDXW'(DEPTH - 1 - a);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NRD; k++) begin
                    check($sformatf("%s rd%0d z%0d ra=%0d", tag, k, 1 - d, ra[k]), act_rd(d, k), '0);
                end
            end
        end
    endtask

    typedef struct {
        logic [1:0]      we;
        logic [IDXW-1:0] wa0, wa1;
        logic [XLEN-1:0] wd0, wd1;
        logic [IDXW-1:0] ra0;
        logic [XLEN-1:0] same_z1, next_z1, same_z0, next_z0;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // Directed vectors, applied in order starting from a cleared file.
        vecs[0] = '{2'b01, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        5'd5,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{2'b11, 5'd7,  5'd7, 32'h11111111, 32'h22222222, 5'd7,
                    32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
        vecs[2] = '{2'b01, 5'd0,  5'd0, 32'hFFFFFFFF, 32'h0,        5'd0,
                    32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3] = '{2'b10, 5'd0,  5'd0, 32'h0,        32'h12345678, 5'd0,
                    32'h0,        32'h0,        32'h12345678, 32'h12345678};
        vecs[4] = '{2'b11, 5'd3,  5'd4, 32'h0A0A0A0A, 32'h0B0B0B0B, 5'd3,
                    32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A};
        vecs[5] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        5'd4,
                    32'h0B0B0B0B, 32'h0B0B0B0B, 32'h0B0B0B0B, 32'h0B0B0B0B};
        vecs[6] = '{2'b01, 5'd5,  5'd0, 32'hCAFEF00D, 32'h0,        5'd5,
                    32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7] = '{2'b10, 5'd1,  5'd9, 32'h0,        32'hA5A5A5A5, 5'd9,
                    32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[8] = '{2'b01, 5'd12, 5'd0, 32'h00000005, 32'h0,        5'd7,
                    32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};

        for (int d = 0; d < 2; d++) begin
            clear_left[d] = 0;
            done_now[d]   = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[d][i] = '0;
        end

        // ---- Reset and initial clear sweep ----
        reset = 1'b1;
        set_idle();
        ra[0] = '0;
        ra[1] = 5'd17;
        #1;
        check_all("in_reset");
        tick();
        reset = 1'b0;
        sweep_measure("clear");
        read_all_zero("after_clear");

        // ---- Directed write/read vectors: same cycle, then next cycle ----
        ra[1] = '0;
        for (int i = 0; i < 9; i++) begin
            we    = vecs[i].we;
            wa[0] = vecs[i].wa0;
            wa[1] = vecs[i].wa1;
            wd[0] = vecs[i].wd0;
            wd[1] = vecs[i].wd1;
            ra[0] = vecs[i].ra0;
            #1;
            check($sformatf("vec%0d same z1", i), act_rd(0, 0), vecs[i].same_z1);
            check($sformatf("vec%0d same z0", i), act_rd(1, 0), vecs[i].same_z0);
            tick();
            set_idle();
            #1;
            check($sformatf("vec%0d next z1", i), act_rd(0, 0), vecs[i].next_z1);
            check($sformatf("vec%0d next z0", i), act_rd(1, 0), vecs[i].next_z0);
        end

        // ---- Writes while clearing are ignored ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            we    = 2'b11;
            wa[0] = 5'd3;
            wa[1] = 5'd4;
            wd[0] = 32'h33333333 + XLEN'(i);
            wd[1] = 32'h44444444 + XLEN'(i);
            ra[0] = 5'd3;
            ra[1] = 5'd4;
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("wclr busy z%0d", 1 - d), XLEN'(act_busy(d)), XLEN'(1));
                check($sformatf("wclr rd0 z%0d", 1 - d), act_rd(d, 0), '0);
                check($sformatf("wclr rd1 z%0d", 1 - d), act_rd(d, 1), '0);
            end
            tick();
        end
        set_idle();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                #1;
                check_all("wclr_wait");
                if (if_z0.clr_done === 1'b1) seen = 1'b1;
                tick();
            end
            check("wclr clr_done timeout", XLEN'(seen), XLEN'(1));
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("wclr x3 z%0d", 1 - d), act_rd(d, 0), '0);
            check($sformatf("wclr x4 z%0d", 1 - d), act_rd(d, 1), '0);
        end

        // ---- Randomised traffic against the model ----
        for (int i = 0; i < 400; i++) begin
            we = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                wa[p] = ($urandom_range(0, 2) == 0) ? IDXW'($urandom_range(0, 3)) : IDXW'($urandom);
                wd[p] = $urandom;
            end
            for (int k = 0; k < NRD; k++) begin
                ra[k] = ($urandom_range(0, 2) == 0) ? IDXW'($urandom_range(0, 3)) : IDXW'($urandom);
            end
            #1;
            check_all("rand");
            tick();
        end

        // ---- Reset from RUN, then reset again mid-sweep ----
        set_idle();
        reset = 1'b1;
        ra[0] = IDXW'($urandom_range(1, DEPTH - 1));
        ra[1] = '0;
        #1;
        check_all("reset_run");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_all("mid1");
            tick();
        end
        reset = 1'b1;
        #1;
        check_all("mid_reset");
        tick();
        reset = 1'b0;
        sweep_measure("restart");
        read_all_zero("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
